// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 width codes, access
// size codes, FSM state encoding and small decode helpers.
package lsu_pkg;

   // RISC-V load/store funct3 encodings (stores use only 000..011)
   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_D  = 3'b011;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;
   localparam logic [2:0] F3_WU = 3'b110;

   // Access size: number of bytes is 1 << size
   typedef enum logic [1:0] {
      SZ_B = 2'd0,
      SZ_H = 2'd1,
      SZ_W = 2'd2,
      SZ_D = 2'd3
   } size_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_RESP = 2'd2
   } state_e;

   // Low two funct3 bits carry the size for both signed and unsigned forms
   function automatic size_e f3_size(input logic [2:0] f3);
      return size_e'(f3[1:0]);
   endfunction

   // Stores only have B/H/W/D; loads have everything except 111
   function automatic logic f3_valid(input logic wen, input logic [2:0] f3);
      return wen ? (f3[2] == 1'b0) : (f3 != 3'b111);
   endfunction

   function automatic logic misaligned(input size_e sz, input logic [2:0] off);
      logic mis;
      case (sz)
         SZ_B:    mis = 1'b0;
         SZ_H:    mis = off[0];
         SZ_W:    mis = |off[1:0];
         default: mis = |off;
      endcase
      return mis;
   endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering for the load/store unit: store data shift, write
// strobe generation, and load extract plus sign/zero extension.
// Lanes pushed past the top of the doubleword are simply dropped, so an
// access that crosses the doubleword boundary loses its upper bytes.
module lsu_align
   import lsu_pkg::*;
#(
   parameter int XLEN = 64
) (
   input  logic [2:0]            st_size_code,
   input  logic [$clog2(XLEN/8)-1:0] st_off,
   input  logic [XLEN-1:0]       st_wdata,
   output logic [XLEN-1:0]       st_lane_data,
   output logic [XLEN/8-1:0]     st_strb,
   input  logic [2:0]            ld_funct3,
   input  logic [$clog2(XLEN/8)-1:0] ld_off,
   input  logic [XLEN-1:0]       ld_rdata,
   output logic [XLEN-1:0]       ld_data
);

   localparam int NB = XLEN / 8;

   size_e            st_size;
   size_e            ld_size;
   logic [NB-1:0]    st_mask;
   logic [NB-1:0]    ld_mask;
   logic [XLEN-1:0]  shifted;
   logic             sign_bit;
   logic             ext_bit;

   assign st_size = f3_size(st_size_code);
   assign ld_size = f3_size(ld_funct3);

   // Per-lane masks covering the first (1 << size) bytes of the access
   for (genvar gi = 0; gi < NB; gi++) begin : g_mask
      assign st_mask[gi] = (gi < (1 << st_size));
      assign ld_mask[gi] = (gi < (1 << ld_size));
   end

   assign st_lane_data = st_wdata << {st_off, 3'b000};
   assign st_strb      = st_mask << st_off;

   assign shifted = ld_rdata >> {ld_off, 3'b000};

   // Pick the top bit of the accessed field for sign extension
   always_comb begin
      sign_bit = shifted[XLEN-1];
      case (ld_size)
         SZ_B:    sign_bit = shifted[7];
         SZ_H:    sign_bit = shifted[15];
         SZ_W:    sign_bit = shifted[31];
         default: sign_bit = shifted[XLEN-1];
      endcase
   end

   // funct3[2] marks the unsigned load forms
   assign ext_bit = sign_bit & ~ld_funct3[2];

   for (genvar gi = 0; gi < NB; gi++) begin : g_ext
      assign ld_data[8*gi +: 8] = ld_mask[gi] ? shifted[8*gi +: 8] : {8{ext_bit}};
   end

endmodule

// File: rtl/lsu.sv
// Load/store unit: accepts one memory operation at a time from execute,
// runs a req/ack transaction on a doubleword data bus and returns the
// extended load result. Stalls the pipeline while a transaction is open.
// Build option LSU_MISALIGN_CHECK_EN: when defined, misaligned accesses
// fault without touching the bus; otherwise they go to the bus with lanes
// past byte 7 dropped. Invalid funct3 always faults.
module lsu
   import lsu_pkg::*;
#(
   parameter int ADDR_W = 64,
   parameter int XLEN   = 64
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              req_valid_i,
   output logic              req_ready_o,
   input  logic              wen_i,
   input  logic [2:0]        funct3_i,
   input  logic [ADDR_W-1:0] addr_i,
   input  logic [XLEN-1:0]   wdata_i,
   output logic              dmem_req_o,
   output logic              dmem_we_o,
   output logic [ADDR_W-1:0] dmem_addr_o,
   output logic [XLEN-1:0]   dmem_wdata_o,
   output logic [XLEN/8-1:0] dmem_wstrb_o,
   input  logic              dmem_ack_i,
   input  logic [XLEN-1:0]   dmem_rdata_i,
   output logic              resp_valid_o,
   output logic [XLEN-1:0]   load_data_o,
   output logic              fault_o,
   output logic              stall_o
);

   localparam int NB    = XLEN / 8;
   localparam int OFF_W = $clog2(NB);

   state_e             state_reg;
   logic               wen_reg;
   logic [2:0]         funct3_reg;
   logic [OFF_W-1:0]   off_reg;
   logic               dmem_req_reg;
   logic               dmem_we_reg;
   logic [ADDR_W-1:0]  dmem_addr_reg;
   logic [XLEN-1:0]    dmem_wdata_reg;
   logic [NB-1:0]      dmem_wstrb_reg;
   logic               resp_valid_reg;
   logic [XLEN-1:0]    load_data_reg;
   logic               fault_reg;

   logic [OFF_W-1:0]   in_off;
   logic [XLEN-1:0]    st_lane_data;
   logic [NB-1:0]      st_strb;
   logic [XLEN-1:0]    ld_data;
   logic               acc_fault;

   assign in_off = addr_i[OFF_W-1:0];

   // Store lanes come from the incoming operation; load extraction uses the
   // latched offset and funct3 since rdata arrives later
   lsu_align #(.XLEN(XLEN)) u_align (
      .st_size_code (funct3_i),
      .st_off       (in_off),
      .st_wdata     (wdata_i),
      .st_lane_data (st_lane_data),
      .st_strb      (st_strb),
      .ld_funct3    (funct3_reg),
      .ld_off       (off_reg),
      .ld_rdata     (dmem_rdata_i),
      .ld_data      (ld_data)
   );

   // Decide at accept time whether the operation completes without the bus
   always_comb begin
      acc_fault = !f3_valid(wen_i, funct3_i);
`ifdef LSU_MISALIGN_CHECK_EN
      if (misaligned(f3_size(funct3_i), in_off)) begin
         acc_fault = 1'b1;
      end
`endif
   end

   // Transaction FSM with registered bus and response outputs
   always_ff @(posedge clock) begin
      if (reset) begin
         state_reg      <= ST_IDLE;
         wen_reg        <= 1'b0;
         funct3_reg     <= 3'b000;
         off_reg        <= '0;
         dmem_req_reg   <= 1'b0;
         dmem_we_reg    <= 1'b0;
         dmem_addr_reg  <= '0;
         dmem_wdata_reg <= '0;
         dmem_wstrb_reg <= '0;
         resp_valid_reg <= 1'b0;
         load_data_reg  <= '0;
         fault_reg      <= 1'b0;
      end else begin
         resp_valid_reg <= 1'b0;
         case (state_reg)
            ST_IDLE: begin
               if (req_valid_i) begin
                  wen_reg    <= wen_i;
                  funct3_reg <= funct3_i;
                  off_reg    <= in_off;
                  if (acc_fault) begin
                     state_reg      <= ST_RESP;
                     resp_valid_reg <= 1'b1;
                     fault_reg      <= 1'b1;
                     load_data_reg  <= '0;
                  end else begin
                     state_reg      <= ST_REQ;
                     dmem_req_reg   <= 1'b1;
                     dmem_we_reg    <= wen_i;
                     dmem_addr_reg  <= {addr_i[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                     dmem_wdata_reg <= st_lane_data;
                     dmem_wstrb_reg <= wen_i ? st_strb : '0;
                  end
               end
            end
            ST_REQ: begin
               if (dmem_ack_i) begin
                  state_reg      <= ST_RESP;
                  dmem_req_reg   <= 1'b0;
                  dmem_we_reg    <= 1'b0;
                  resp_valid_reg <= 1'b1;
                  fault_reg      <= 1'b0;
                  load_data_reg  <= wen_reg ? '0 : ld_data;
               end
            end
            ST_RESP: begin
               state_reg <= ST_IDLE;
            end
            default: begin
               state_reg <= ST_IDLE;
            end
         endcase
      end
   end

   assign req_ready_o  = (state_reg == ST_IDLE);
   assign stall_o      = ((state_reg == ST_IDLE) && req_valid_i) || (state_reg == ST_REQ);
   assign dmem_req_o   = dmem_req_reg;
   assign dmem_we_o    = dmem_we_reg;
   assign dmem_addr_o  = dmem_addr_reg;
   assign dmem_wdata_o = dmem_wdata_reg;
   assign dmem_wstrb_o = dmem_wstrb_reg;
   assign resp_valid_o = resp_valid_reg;
   assign load_data_o  = load_data_reg;
   assign fault_o      = fault_reg;

endmodule

// File: tb/tb_lsu.sv
// Scoreboard bench for lsu: stimulus pushes expected bus requests and
// responses, a bus model checks/acks requests and a monitor checks
// responses as they appear.
`timescale 1ns/1ps
module tb_lsu;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        req_valid_i = 1'b0;
   logic        req_ready_o;
   logic        wen_i = 1'b0;
   logic [2:0]  funct3_i = 3'b000;
   logic [63:0] addr_i = 64'h0;
   logic [63:0] wdata_i = 64'h0;
   logic        dmem_req_o;
   logic        dmem_we_o;
   logic [63:0] dmem_addr_o;
   logic [63:0] dmem_wdata_o;
   logic [7:0]  dmem_wstrb_o;
   logic        dmem_ack_i;
   logic [63:0] dmem_rdata_i;
   logic        resp_valid_o;
   logic [63:0] load_data_o;
   logic        fault_o;
   logic        stall_o;

   logic        bus_ack = 1'b0;
   logic        spur_ack = 1'b0;
   logic [63:0] bus_rdata = 64'h0;

   assign dmem_ack_i   = bus_ack | spur_ack;
   assign dmem_rdata_i = bus_rdata;

   lsu #(.ADDR_W(64), .XLEN(64)) dut (
      .clock        (clock),
      .reset        (reset),
      .req_valid_i  (req_valid_i),
      .req_ready_o  (req_ready_o),
      .wen_i        (wen_i),
      .funct3_i     (funct3_i),
      .addr_i       (addr_i),
      .wdata_i      (wdata_i),
      .dmem_req_o   (dmem_req_o),
      .dmem_we_o    (dmem_we_o),
      .dmem_addr_o  (dmem_addr_o),
      .dmem_wdata_o (dmem_wdata_o),
      .dmem_wstrb_o (dmem_wstrb_o),
      .dmem_ack_i   (dmem_ack_i),
      .dmem_rdata_i (dmem_rdata_i),
      .resp_valid_o (resp_valid_o),
      .load_data_o  (load_data_o),
      .fault_o      (fault_o),
      .stall_o      (stall_o)
   );

   always #5 clock = ~clock;

   typedef struct {
      int          tid;
      logic        fault;
      logic [63:0] data;
      int          lat;
      int          a0;
   } resp_t;

   typedef struct {
      int          tid;
      logic        we;
      logic [63:0] addr;
      logic [63:0] wdata;
      logic        chk_wdata;
      logic [7:0]  wstrb;
      int          delay;
      logic [63:0] rdata;
   } bus_t;

   resp_t resp_q[$];
   bus_t  bus_q[$];
   int    checks = 0;
   int    errors = 0;
   int    cyc = 0;

   always @(posedge clock) cyc++;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Bus model: checks the request on its first cycle, stability afterwards,
   // and acks after the requested number of wait cycles
   bus_t        cur;
   int          k = -1;
   logic [63:0] hold_addr, hold_wdata;
   logic [8:0]  hold_ctl;

   always @(negedge clock) begin
      if (!reset && dmem_req_o) begin
         if (k < 0) begin
            if (bus_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL bus_unexpected_req: got request addr %h expected no request", dmem_addr_o);
               cur.tid = -1; cur.we = 1'b0; cur.addr = 64'h0; cur.wdata = 64'h0;
               cur.chk_wdata = 1'b0; cur.wstrb = 8'h0; cur.delay = 0; cur.rdata = 64'h0;
            end else begin
               cur = bus_q.pop_front();
               chk("bus_addr", dmem_addr_o, cur.addr);
               chk("bus_we", {63'h0, dmem_we_o}, {63'h0, cur.we});
               chk("bus_wstrb", {56'h0, dmem_wstrb_o}, {56'h0, cur.wstrb});
               if (cur.chk_wdata) chk("bus_wdata", dmem_wdata_o, cur.wdata);
            end
            k = 0;
            hold_addr  = dmem_addr_o;
            hold_wdata = dmem_wdata_o;
            hold_ctl   = {dmem_we_o, dmem_wstrb_o};
         end else begin
            k++;
            chk("bus_addr_stable", dmem_addr_o, hold_addr);
            chk("bus_wdata_stable", dmem_wdata_o, hold_wdata);
            chk("bus_ctl_stable", {55'h0, dmem_we_o, dmem_wstrb_o}, {55'h0, hold_ctl});
         end
         chk("stall_in_req", {63'h0, stall_o}, 64'h1);
         bus_ack   = (k == cur.delay);
         bus_rdata = bus_ack ? cur.rdata : 64'h0;
      end else begin
         bus_ack   = 1'b0;
         bus_rdata = 64'h0;
         k = -1;
      end
   end

   // Response monitor
   always @(negedge clock) begin
      if (!reset && resp_valid_o) begin
         if (resp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL resp_unexpected: got resp_valid_o=1 expected 0 (load_data %h)", load_data_o);
         end else begin
            resp_t r;
            r = resp_q.pop_front();
            chk("resp_fault", {63'h0, fault_o}, {63'h0, r.fault});
            chk("resp_load_data", load_data_o, r.data);
            chk("resp_latency", 64'(cyc - r.a0), 64'(r.lat));
            chk("resp_stall", {63'h0, stall_o}, 64'h0);
            chk("resp_ready", {63'h0, req_ready_o}, 64'h0);
            $display("txn %0d: fault=%0b load_data=%h latency=%0d", r.tid, fault_o, load_data_o, cyc - r.a0);
         end
      end
   end

   task automatic run(input int tid, input logic wen, input logic [2:0] f3,
                      input logic [63:0] addr, input logic [63:0] wdata,
                      input logic exp_fault, input logic [63:0] exp_data, input int lat,
                      input logic [63:0] exp_wdata, input logic [7:0] exp_strb,
                      input int delay, input logic [63:0] rdata);
      resp_t r;
      bus_t  b;
      int    n;
      @(posedge clock);
      #1;
      r.tid = tid; r.fault = exp_fault; r.data = exp_data; r.lat = lat; r.a0 = cyc;
      resp_q.push_back(r);
      if (!exp_fault) begin
         b.tid = tid; b.we = wen; b.addr = {addr[63:3], 3'b000}; b.wdata = exp_wdata;
         b.chk_wdata = wen; b.wstrb = exp_strb; b.delay = delay; b.rdata = rdata;
         bus_q.push_back(b);
      end
      req_valid_i = 1'b1;
      wen_i       = wen;
      funct3_i    = f3;
      addr_i      = addr;
      wdata_i     = wdata;
      @(negedge clock);
      chk("accept_stall", {63'h0, stall_o}, 64'h1);
      chk("accept_ready", {63'h0, req_ready_o}, 64'h1);
      n = 0;
      do begin
         @(negedge clock);
         n++;
      end while (stall_o && n < 40);
      if (n >= 40) begin
         checks++;
         errors++;
         $display("FAIL txn_timeout: got stall_o=1 after %0d cycles expected completion", n);
      end
      @(posedge clock);
      #1;
      req_valid_i = 1'b0;
      wen_i       = 1'b0;
      funct3_i    = 3'b000;
      addr_i      = 64'h0;
      wdata_i     = 64'h0;
      @(negedge clock);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: got no finish expected completion");
      $fatal(1, "timeout");
   end

   initial begin
      repeat (3) @(posedge clock);
      #1 reset = 1'b0;
      @(negedge clock);
      chk("rst_dmem_req", {63'h0, dmem_req_o}, 64'h0);
      chk("rst_dmem_we", {63'h0, dmem_we_o}, 64'h0);
      chk("rst_dmem_addr", dmem_addr_o, 64'h0);
      chk("rst_dmem_wdata", dmem_wdata_o, 64'h0);
      chk("rst_dmem_wstrb", {56'h0, dmem_wstrb_o}, 64'h0);
      chk("rst_resp_valid", {63'h0, resp_valid_o}, 64'h0);
      chk("rst_load_data", load_data_o, 64'h0);
      chk("rst_fault", {63'h0, fault_o}, 64'h0);
      chk("rst_stall", {63'h0, stall_o}, 64'h0);
      chk("rst_ready", {63'h0, req_ready_o}, 64'h1);

      // ack outside REQ must be ignored
      @(posedge clock); #1 spur_ack = 1'b1;
      @(posedge clock); #1 spur_ack = 1'b0;
      @(negedge clock);
      chk("spur_ack_ready", {63'h0, req_ready_o}, 64'h1);
      chk("spur_ack_req", {63'h0, dmem_req_o}, 64'h0);

      //  tid wen f3      addr          wdata                 flt data                   lat exp_wdata              strb   dly rdata
      run(1,  1, 3'b010, 64'h1004, 64'h00000000DEADBEEF, 0, 64'h0,                 2, 64'hDEADBEEF00000000, 8'hF0, 0, 64'h0);
      run(2,  0, 3'b000, 64'h2003, 64'h0,                0, 64'hFFFFFFFFFFFFFF80, 2, 64'h0,              8'h00, 0, 64'h0000000080000000);
      run(3,  0, 3'b101, 64'h2006, 64'h0,                0, 64'h000000000000BEEF, 3, 64'h0,              8'h00, 1, 64'hBEEF000000000000);
`ifdef LSU_MISALIGN_CHECK_EN
      run(4,  0, 3'b010, 64'h1002, 64'h0,                1, 64'h0,                 1, 64'h0,              8'h00, 0, 64'h0);
`else
      run(4,  0, 3'b010, 64'h1002, 64'h0,                0, 64'h0000000033445566, 2, 64'h0,              8'h00, 0, 64'h1122334455667788);
`endif
      run(5,  0, 3'b011, 64'h3000, 64'h0,                0, 64'h8123456789ABCDEF, 5, 64'h0,              8'h00, 3, 64'h8123456789ABCDEF);
      run(6,  0, 3'b001, 64'h2002, 64'h0,                0, 64'hFFFFFFFFFFFF8001, 2, 64'h0,              8'h00, 0, 64'h0000000080010000);
      run(7,  0, 3'b110, 64'h2004, 64'h0,                0, 64'h00000000F0000001, 2, 64'h0,              8'h00, 0, 64'hF000000100000000);
      run(8,  0, 3'b100, 64'h2007, 64'h0,                0, 64'h00000000000000AB, 2, 64'h0,              8'h00, 0, 64'hAB00000000000000);

      // load result holds between responses
      repeat (2) @(negedge clock);
      chk("hold_load_data", load_data_o, 64'h00000000000000AB);
      chk("hold_fault", {63'h0, fault_o}, 64'h0);

      run(9,  1, 3'b000, 64'h1007, 64'h112233445566775A, 0, 64'h0,                 2, 64'h5A00000000000000, 8'h80, 0, 64'h0);
      run(10, 1, 3'b001, 64'h1002, 64'h0000000000001234, 0, 64'h0,                 4, 64'h0000000012340000, 8'h0C, 2, 64'h0);
`ifdef LSU_MISALIGN_CHECK_EN
      run(11, 1, 3'b011, 64'h1005, 64'h0102030405060708, 1, 64'h0,                 1, 64'h0,              8'h00, 0, 64'h0);
      run(12, 0, 3'b010, 64'h1006, 64'h0,                1, 64'h0,                 1, 64'h0,              8'h00, 0, 64'h0);
`else
      run(11, 1, 3'b011, 64'h1005, 64'h0102030405060708, 0, 64'h0,                 2, 64'h0607080000000000, 8'hE0, 0, 64'h0);
      run(12, 0, 3'b010, 64'h1006, 64'h0,                0, 64'h000000000000AABB, 2, 64'h0,              8'h00, 0, 64'hAABBCCDD11223344);
`endif
      run(13, 1, 3'b100, 64'h1000, 64'h00000000CAFEF00D, 1, 64'h0,                 1, 64'h0,              8'h00, 0, 64'h0);
      run(14, 0, 3'b111, 64'h1000, 64'h0,                1, 64'h0,                 1, 64'h0,              8'h00, 0, 64'h0);

      // reset during the second REQ cycle abandons the transaction
      begin
         bus_t b;
         @(posedge clock);
         #1;
         b.tid = 15; b.we = 1'b0; b.addr = 64'h3000; b.wdata = 64'h0; b.chk_wdata = 1'b0;
         b.wstrb = 8'h00; b.delay = 20; b.rdata = 64'h0;
         bus_q.push_back(b);
         req_valid_i = 1'b1;
         wen_i       = 1'b0;
         funct3_i    = 3'b011;
         addr_i      = 64'h3000;
         @(posedge clock); #1;
         @(posedge clock); #1 reset = 1'b1;
         @(negedge clock);
         chk("rstmid_req_before", {63'h0, dmem_req_o}, 64'h1);
         @(posedge clock); #1;
         reset       = 1'b0;
         req_valid_i = 1'b0;
         addr_i      = 64'h0;
         funct3_i    = 3'b000;
         @(negedge clock);
         chk("rstmid_req_dropped", {63'h0, dmem_req_o}, 64'h0);
         chk("rstmid_ready", {63'h0, req_ready_o}, 64'h1);
         chk("rstmid_resp_valid", {63'h0, resp_valid_o}, 64'h0);
         chk("rstmid_load_data", load_data_o, 64'h0);
         $display("txn 15: reset in REQ, transaction abandoned");
      end

      repeat (8) @(negedge clock);
      chk("resp_queue_empty", 64'(resp_q.size()), 64'h0);
      chk("bus_queue_empty", 64'(bus_q.size()), 64'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/lsu.md
# lsu

Load/store unit between the execute stage and the memory stage of the RV64IM core. It takes one memory operation at a time (address from the ALU, store data, funct3) and runs a request/acknowledge transaction with a doubleword-wide data memory. It returns the sign- or zero-extended load result that the memory stage writes back. While a transaction is outstanding it stalls the pipeline.

## Interface
Parameters:
- ADDR_W, 64, byte-address width
- XLEN, 64, data width; dmem is XLEN bits wide with XLEN/8 byte lanes

Ports:
- clock  in  1  single clock, rising edge
- reset  in  1  synchronous, active-high
- req_valid_i  in  1  execute stage presents a load or store
- req_ready_o  out  1  unit can accept an operation this cycle
- wen_i  in  1  1 = store, 0 = load
- funct3_i  in  3  RISC-V width/sign code (LB/LH/LW/LD/LBU/LHU/LWU; SB/SH/SW/SD)
- addr_i  in  ADDR_W  effective byte address
- wdata_i  in  XLEN  store data, right-aligned
- dmem_req_o  out  1  bus request
- dmem_we_o  out  1  bus write
- dmem_addr_o  out  ADDR_W  doubleword-aligned address; bits [2:0] are 0
- dmem_wdata_o  out  XLEN  lane-shifted store data
- dmem_wstrb_o  out  XLEN/8  byte-lane write enables; 0 for loads
- dmem_ack_i  in  1  bus completes the transaction
- dmem_rdata_i  in  XLEN  read doubleword, valid with ack
- resp_valid_o  out  1  one-cycle completion pulse
- load_data_o  out  XLEN  extended load result; 0 for stores and faults
- fault_o  out  1  misaligned access, valid with resp_valid_o
- stall_o  out  1  freezes the upstream pipeline

## Operation
- FSM states: IDLE, REQ, RESP.
- IDLE:
  - req_ready_o=1.
  - On req_valid_i, latch wen, funct3, addr and wdata.
  - If the access is aligned, go to REQ; if misaligned, go to RESP with fault=1.
- REQ:
  - dmem_req_o=1; all dmem_* outputs are held stable from the latched values.
  - On dmem_ack_i: capture rdata, extend it and go to RESP.
- RESP:
  - resp_valid_o=1 for exactly one cycle, then go to IDLE.
  - req_ready_o=0, so the still-asserted req_valid_i of the same operation is not re-accepted.
- Alignment: byte=any, half=addr[0]==0, word=addr[1:0]==0, double=addr[2:0]==0.
- Store lanes, with off=addr[2:0]:
  - dmem_wdata_o = wdata_i << (8*off).
  - dmem_wstrb_o = {1,3,15,255}[size] << off.
- Load extraction:
  - shifted = dmem_rdata_i >> (8*off), truncated to the access size.
  - Sign-extend for LB/LH/LW; zero-extend for LBU/LHU/LWU; LD passes through.
- Invalid funct3 (store 100-111, load 111): treated as a fault, and no bus request is issued.
- dmem_ack_i outside REQ is ignored.

## Timing
- Reset values:
  - State = IDLE.
  - dmem_req_o, dmem_we_o, resp_valid_o, fault_o and stall_o are 0.
  - dmem_addr_o, dmem_wdata_o, dmem_wstrb_o and load_data_o are 0.
- stall_o = (IDLE & req_valid_i) | REQ. It is 0 in RESP, so the pipeline advances on that edge.
- Latency from accept to resp_valid_o:
  - Aligned access: 2 + N cycles, where N is the number of REQ cycles before ack. Ack in the first REQ cycle gives 2 cycles.
  - Faulting access: 1 cycle.
- load_data_o and fault_o are registered. They hold their values until the next resp_valid_o and update only on entry to RESP.
- Reset mid-REQ: dmem_req_o drops on the next edge and the transaction is abandoned. The bus must discard it. No resp_valid_o is produced.

## Configuration
- LSU_MISALIGN_CHECK_EN
  - Defined: misaligned accesses fault as described above.
  - Undefined:
    - No fault is raised for misalignment; every access with a valid funct3 goes to the bus.
    - Lanes past byte 7 are dropped from the strobe and from the load data; the missing bytes read as 0 before extension.
    - Invalid funct3 still faults.

## Structure
- The funct3 encodings, size codes and the FSM state encoding go in the shared define header, alongside the existing ALU op codes.
- One combinational sub-module, lsu_align, holds the store-lane shift, the strobe generation and the load extract/extend. The FSM and registers stay in lsu.

## Test plan
- SW, addr 0x1004, wdata 0xDEADBEEF, ack in the first REQ cycle:
  - dmem_addr_o=0x1000, dmem_wstrb_o=0xF0, dmem_wdata_o=0xDEADBEEF_00000000.
  - resp_valid_o 2 cycles after accept, load_data_o=0.
- LB, addr 0x2003, rdata 0x00000000_80000000 → load_data_o=0xFFFFFFFF_FFFFFF80.
- LHU, addr 0x2006, rdata 0xBEEF0000_00000000 → load_data_o=0x0000_0000_0000_BEEF.
- LW, addr 0x1002, with the macro defined:
  - dmem_req_o stays 0.
  - fault_o=1 with resp_valid_o one cycle after accept.
- LD, addr 0x3000, ack held off for 3 cycles:
  - stall_o high from accept through the ack cycle, then 0 in RESP.
  - dmem_* stable throughout; resp_valid_o 5 cycles after accept.
- reset asserted in the second REQ cycle → dmem_req_o=0 next cycle, FSM returns to IDLE, no resp_valid_o.
